mm_stream_tx: RTL

//  Source side of the matrix-multiply input stream. Holds M1/M2 operands in a local

---
 rtl/mm_pkg.sv | 11 +
 rtl/mm_stream_tx_if.sv | 15 +
 rtl/mm_tx_regfile.sv | 26 ++
 rtl/mm_stream_tx.sv | 105 ++++++++++
 4 files changed

// File: rtl/mm_pkg.sv
// Shared types and defaults for the matrix-multiply input stream source.
package mm_pkg;
  localparam int MM_DATA_W = 8;
  localparam int MM_DIM_W  = 2;

  typedef enum logic [2:0] {
    IDLE, SEND_M1, SEND_M2, WAIT_HI, WAIT_LO, DONE
  } tx_state_e;

  typedef logic [MM_DIM_W-1:0] dim_t;
endpackage

// File: rtl/mm_stream_tx_if.sv
// Element stream toward the MM controller plus its status handshake.
interface mm_stream_tx_if #(parameter int DATA_W = 8);
  logic              tx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              col_end;
  logic              row_end;
  logic              mm_busy;
  logic              mm_valid;
  logic              mm_is_legal;

  modport master (output tx_valid, tx_data, col_end, row_end,
                  input  mm_busy, mm_valid, mm_is_legal);
  modport slave  (input  tx_valid, tx_data, col_end, row_end,
                  output mm_busy, mm_valid, mm_is_legal);
endinterface

// File: rtl/mm_tx_regfile.sv
// Two operand banks, one write port, one combinational read port.
module mm_tx_regfile
  import mm_pkg::*;
#(
  parameter int DATA_W = MM_DATA_W,
  parameter int DIM_W  = MM_DIM_W
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic                 wsel,
  input  logic [2*DIM_W-1:0]   waddr,
  input  logic [DATA_W-1:0]    wdata,
  input  logic                 rsel,
  input  logic [2*DIM_W-1:0]   raddr,
  output logic [DATA_W-1:0]    rdata
);
  localparam int DEPTH = 1 << (2*DIM_W);

  // Contents are deliberately not reset.
  logic [DATA_W-1:0] mem [2*DEPTH];

  always_ff @(posedge clk)
    if (we) mem[{wsel, waddr}] <= wdata;

  assign rdata = mem[{rsel, raddr}];
endmodule

// File: rtl/mm_stream_tx.sv
// Streams M1 then M2 row-major with col/row framing, then tracks the
// controller's busy window, counting result beats.
module mm_stream_tx
  import mm_pkg::*;
#(
  parameter int DATA_W = MM_DATA_W,
  parameter int DIM_W  = MM_DIM_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_we,
  input  logic                 cfg_sel,
  input  logic [2*DIM_W-1:0]   cfg_addr,
  input  logic [DATA_W-1:0]    cfg_wdata,
  output logic                 cfg_ready,
  input  logic                 start,
  input  logic [DIM_W-1:0]     m1_rows,
  input  logic [DIM_W-1:0]     m1_cols,
  input  logic [DIM_W-1:0]     m2_rows,
  input  logic [DIM_W-1:0]     m2_cols,
  mm_stream_tx_if.master       mm,
  output logic [2*DIM_W:0]     res_cnt,
  output logic                 illegal_seen,
  output logic                 done
);
  tx_state_e         state;
  logic [DIM_W-1:0]  row, col;
  logic [DIM_W-1:0]  m1r, m1c, m2r, m2c;
  logic [DIM_W-1:0]  cur_rows, cur_cols;
  logic [DATA_W-1:0] rdata;
  logic              sending;

  assign sending   = (state == SEND_M1) || (state == SEND_M2);
  assign cur_rows  = (state == SEND_M2) ? m2r : m1r;
  assign cur_cols  = (state == SEND_M2) ? m2c : m1c;
  assign cfg_ready = (state == IDLE);
  assign done      = (state == DONE);

  // Framing is decoded straight from state so reset clears it asynchronously.
  assign mm.tx_valid = sending;
  assign mm.tx_data  = sending ? rdata : '0;
  assign mm.col_end  = sending && (col == cur_cols);
  assign mm.row_end  = sending && (col == cur_cols) && (row == cur_rows);

  mm_tx_regfile #(.DATA_W(DATA_W), .DIM_W(DIM_W)) u_rf (
    .clk   (clk),
    .we    (cfg_we && cfg_ready),
    .wsel  (cfg_sel),
    .waddr (cfg_addr),
    .wdata (cfg_wdata),
    .rsel  (state == SEND_M2),
    .raddr ({row, col}),
    .rdata (rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      row          <= '0;
      col          <= '0;
      m1r          <= '0;
      m1c          <= '0;
      m2r          <= '0;
      m2c          <= '0;
      res_cnt      <= '0;
      illegal_seen <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          m1r          <= m1_rows;
          m1c          <= m1_cols;
          m2r          <= m2_rows;
          m2c          <= m2_cols;
          row          <= '0;
          col          <= '0;
          res_cnt      <= '0;
          illegal_seen <= 1'b0;
          state        <= SEND_M1;
        end
        SEND_M1, SEND_M2: begin
          if (col == cur_cols) begin
            col <= '0;
            if (row == cur_rows) begin
              row   <= '0;
              state <= (state == SEND_M1) ? SEND_M2 : WAIT_HI;
            end else begin
              row <= row + 1'b1;
            end
          end else begin
            col <= col + 1'b1;
          end
        end
        WAIT_HI: if (mm.mm_busy)  state <= WAIT_LO;
        WAIT_LO: if (!mm.mm_busy) state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase

      if ((state == WAIT_HI || state == WAIT_LO) && mm.mm_valid) begin
        if (res_cnt != '1) res_cnt <= res_cnt + 1'b1;
        if (!mm.mm_is_legal) illegal_seen <= 1'b1;
      end
    end
  end
endmodule
